// File: rtl/cv32e40x_fencei_responder.sv
// Responder side of the fence.i flush handshake.
// Waits for the data side to drain, sweeps an invalidate index over every
// instruction-side line, then returns a single-cycle ack to the controller.
// Every output comes straight from a flop.

module cv32e40x_fencei_responder #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fencei_flush_req_i,
    output logic             fencei_flush_ack_o,
    input  logic             lsu_bus_busy_i,
    input  logic             wbuf_empty_i,
    output logic             inval_valid_o,
    output logic [IDX_W-1:0] inval_idx_o,
    input  logic             inval_ready_i,
    output logic             busy_o,
    output logic [15:0]      flush_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StInval,
        StAck,
        StRelease
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_LINES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             inval_valid_q;
    logic             ack_q;
    logic             busy_q;
    logic [15:0]      flush_cnt_q;
    logic             drain_ok;

    // Data side is quiet: no OBI transfers in flight and nothing left to write back.
    assign drain_ok = !lsu_bus_busy_i && wbuf_empty_i;

    // Handshake FSM; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            inval_valid_q <= 1'b0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            flush_cnt_q   <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fencei_flush_req_i) begin
                        state_q <= StDrain;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                StDrain: begin
                    if (drain_ok) begin
                        state_q       <= StInval;
                        inval_valid_q <= 1'b1;
                    end
                end
                StInval: begin
                    if (inval_ready_i) begin
                        if (idx_q == LastIdx) begin
                            state_q       <= StAck;
                            idx_q         <= '0;
                            inval_valid_q <= 1'b0;
                            // The ack is a flop, so it is armed from the request level
                            // seen on the final accept; a withdrawn request gets no ack.
                            ack_q         <= fencei_flush_req_i;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StAck: begin
                    ack_q   <= 1'b0;
                    state_q <= StRelease;
                    if (ack_q) begin
                        flush_cnt_q <= flush_cnt_q + 16'd1;
                    end
                end
                StRelease: begin
                    // A request still held high is the old one; wait for it to drop.
                    if (!fencei_flush_req_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    idx_q         <= '0;
                    inval_valid_q <= 1'b0;
                    ack_q         <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign fencei_flush_ack_o = ack_q;
    assign inval_valid_o      = inval_valid_q;
    assign inval_idx_o        = idx_q;
    assign busy_o             = busy_q;
    assign flush_cnt_o        = flush_cnt_q;

endmodule

// File: tb/tb_cv32e40x_fencei_responder.sv
// Bench for the fence.i responder: three instances (4, 1 and 5 lines) driven
// with randomized drain stalls, backpressure, withdrawals and late releases.
// Expected timing is derived from the handshake rules, not from the FSM.

module tb_cv32e40x_fencei_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic        bbusy [3];
    logic        wbe   [3];
    logic        rdy   [3];
    logic        ack   [3];
    logic        valid [3];
    logic        busy  [3];
    logic [15:0] cnt   [3];
    logic [1:0]  idx0;
    logic [0:0]  idx1;
    logic [2:0]  idx2;

    logic [15:0] cnt_exp [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40x_fencei_responder #(.NUM_LINES(4)) u_d0 (
        .clk                (clk),
        .rst                (rst),
        .fencei_flush_req_i (req[0]),
        .fencei_flush_ack_o (ack[0]),
        .lsu_bus_busy_i     (bbusy[0]),
        .wbuf_empty_i       (wbe[0]),
        .inval_valid_o      (valid[0]),
        .inval_idx_o        (idx0),
        .inval_ready_i      (rdy[0]),
        .busy_o             (busy[0]),
        .flush_cnt_o        (cnt[0])
    );

    cv32e40x_fencei_responder #(.NUM_LINES(1)) u_d1 (
        .clk                (clk),
        .rst                (rst),
        .fencei_flush_req_i (req[1]),
        .fencei_flush_ack_o (ack[1]),
        .lsu_bus_busy_i     (bbusy[1]),
        .wbuf_empty_i       (wbe[1]),
        .inval_valid_o      (valid[1]),
        .inval_idx_o        (idx1),
        .inval_ready_i      (rdy[1]),
        .busy_o             (busy[1]),
        .flush_cnt_o        (cnt[1])
    );

    cv32e40x_fencei_responder #(.NUM_LINES(5)) u_d2 (
        .clk                (clk),
        .rst                (rst),
        .fencei_flush_req_i (req[2]),
        .fencei_flush_ack_o (ack[2]),
        .lsu_bus_busy_i     (bbusy[2]),
        .wbuf_empty_i       (wbe[2]),
        .inval_valid_o      (valid[2]),
        .inval_idx_o        (idx2),
        .inval_ready_i      (rdy[2]),
        .busy_o             (busy[2]),
        .flush_cnt_o        (cnt[2])
    );

    function automatic int num_lines(input int sel);
        case (sel)
            0:       return 4;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] obs_idx(input int sel);
        case (sel)
            0:       return {30'd0, idx0};
            1:       return {31'd0, idx1};
            default: return {29'd0, idx2};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input int sel, input string tag);
        check_eq($sformatf("%s.d%0d.valid", tag, sel), {31'd0, valid[sel]}, 32'd0);
        check_eq($sformatf("%s.d%0d.idx", tag, sel), obs_idx(sel), 32'd0);
        check_eq($sformatf("%s.d%0d.ack", tag, sel), {31'd0, ack[sel]}, 32'd0);
        check_eq($sformatf("%s.d%0d.busy", tag, sel), {31'd0, busy[sel]}, 32'd0);
        check_eq($sformatf("%s.d%0d.cnt", tag, sel), {16'd0, cnt[sel]}, {16'd0, cnt_exp[sel]});
    endtask

    // One flush on instance sel, entered and left at a negedge with the DUT idle.
    // dw: cycles the drain condition is held off; wd: cycle the request is withdrawn
    // (-1 = never); hold: extra cycles req stays high after the ack; pct: ready odds.
    task automatic run_flush(input int sel, input int dw, input int wd, input int hold,
                             input int pct);
        int   nl, acc, ack_c, end_c, r;
        logic wdrawn, exp_valid;
        nl     = num_lines(sel);
        acc    = 0;
        ack_c  = -1;
        end_c  = -1;
        wdrawn = (wd >= 0);
        for (int t = 0; t < 3000; t++) begin
            exp_valid = (t >= 2 + dw) && (ack_c < 0);
            check_eq($sformatf("d%0d.valid@%0d", sel, t), {31'd0, valid[sel]},
                     {31'd0, exp_valid});
            check_eq($sformatf("d%0d.idx@%0d", sel, t), obs_idx(sel),
                     exp_valid ? acc : 0);
            check_eq($sformatf("d%0d.ack@%0d", sel, t), {31'd0, ack[sel]},
                     {31'd0, (t == ack_c) && !wdrawn});
            check_eq($sformatf("d%0d.busy@%0d", sel, t), {31'd0, busy[sel]},
                     {31'd0, (t >= 1) && (end_c < 0 || t <= end_c)});
            if (end_c >= 0 && t == end_c + 1) begin
                if (!wdrawn) cnt_exp[sel] = cnt_exp[sel] + 16'd1;
                check_eq($sformatf("d%0d.cnt", sel), {16'd0, cnt[sel]}, {16'd0, cnt_exp[sel]});
                return;
            end
            if (t == 0) req[sel] = 1'b1;
            if (wd >= 0 && t >= wd) req[sel] = 1'b0;
            if (ack_c >= 0 && t >= ack_c + 1 + hold) req[sel] = 1'b0;
            if (t >= 1 && t <= dw) begin
                r          = $urandom_range(0, 2);
                bbusy[sel] = (r != 1);
                wbe[sel]   = (r == 0);
            end else if (t == dw + 1) begin
                bbusy[sel] = 1'b0;
                wbe[sel]   = 1'b1;
            end else begin
                bbusy[sel] = 1'($urandom_range(0, 1));
                wbe[sel]   = 1'($urandom_range(0, 1));
            end
            rdy[sel] = ($urandom_range(0, 99) < pct);
            if (exp_valid && rdy[sel]) begin
                acc++;
                if (acc == nl) begin
                    ack_c = t + 1;
                    end_c = ack_c + 1 + (wdrawn ? 0 : hold);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL d%0d.timeout: got=not idle exp=idle", sel);
    endtask

    initial begin
        int sel, wd;
        logic found;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; bbusy[i] = 1'b0; wbe[i] = 1'b1; rdy[i] = 1'b0;
            cnt_exp[i] = 16'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_quiet(i, "reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic, drain stall, backpressure, withdrawal, late release.
        run_flush(0, 0, -1, 0, 100);
        run_flush(0, 9, -1, 0, 100);
        run_flush(0, 0, -1, 0, 50);
        run_flush(2, 1, -1, 0, 50);
        run_flush(0, 2, 5, 0, 70);
        run_flush(0, 0, -1, 4, 100);
        run_flush(1, 0, -1, 0, 100);
        run_flush(1, 3, -1, 2, 40);

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 2);
            wd  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 1 + num_lines(sel)) : -1;
            run_flush(sel, $urandom_range(0, 4), wd, $urandom_range(0, 3),
                      $urandom_range(30, 100));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a sweep on the 5-line instance.
        req[2] = 1'b1; bbusy[2] = 1'b0; wbe[2] = 1'b1; rdy[2] = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (valid[2] && idx2 == 3'd2) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL rstmid.reach: got=idx2 not seen exp=idx2 seen");
        end
        rst = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cnt_exp[i] = 16'd0;
            check_quiet(i, "rstmid");
        end
        rst = 1'b0;
        @(negedge clk);
        run_flush(2, 0, -1, 0, 100);

        // Counter wrap from 0xFFFF.
        force u_d0.flush_cnt_q = 16'hFFFF;
        #1;
        release u_d0.flush_cnt_q;
        @(negedge clk);
        cnt_exp[0] = 16'hFFFF;
        check_eq("preload.cnt", {16'd0, cnt[0]}, {16'd0, cnt_exp[0]});
        run_flush(0, 1, -1, 1, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
